// File: rtl/time_tag_emitter.sv
`default_nettype none
//==============================================================================
// time_tag_emitter
//   Decimates timer periods and emits one framed time tag per enabled block ID
//   into a first-word-fall-through FIFO with valid/ready output.
// Revision: 1.0
//==============================================================================
module time_tag_emitter #(
  parameter int CRC_BITS       = 5,
  parameter int MODULE_ID_BITS = 4,
  parameter int BLOCK_ID_BITS  = 2,
  parameter int NUM_BLOCKS     = 4,
  parameter int PERIOD_BITS    = 48,
  parameter int DATA_BITS      = 128,
  parameter int FIFO_DEPTH     = 8,
  parameter int DIV_BITS       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MODULE_ID_BITS-1:0]     module_id,
  input  logic                          period_done,
  input  logic [NUM_BLOCKS-1:0]         block_mask,
  input  logic [NUM_BLOCKS-1:0]         stall,
  input  logic [DIV_BITS-1:0]           tag_div,
  output logic                          tt_valid,
  input  logic                          tt_ready,
  output logic [DATA_BITS-1:0]          tt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   dropped_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int FLG_POS = DATA_BITS - CRC_BITS - 1;
  localparam int MID_MSB = FLG_POS - 1;
  localparam int BID_MSB = MID_MSB - MODULE_ID_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t                     r_state;
  logic [PERIOD_BITS-1:0]     r_period_cnt;
  logic [PERIOD_BITS-1:0]     r_period_snap;
  logic [DIV_BITS-1:0]        r_div_cnt;
  logic [NUM_BLOCKS-1:0]      r_mask_snap;
  logic [NUM_BLOCKS-1:0]      r_pend;
  logic [15:0]                r_dropped;
  logic [DATA_BITS-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_level;

  logic                       w_trigger;
  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic [BLOCK_ID_BITS-1:0]   w_blk_idx;
  logic [NUM_BLOCKS-1:0]      w_pend_next;
  logic [DATA_BITS-1:0]       w_tag;

  assign w_trigger   = period_done & (r_div_cnt >= tag_div);
  assign w_full      = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_push      = (r_state == S_EMIT) & ~w_full;
  assign w_pop       = (r_level != '0) & tt_ready;
  assign w_pend_next = r_pend & ~(NUM_BLOCKS'(1) << w_blk_idx);

  // Lowest still-pending block is the one written this cycle.
  always_comb begin
    w_blk_idx = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_blk_idx = BLOCK_ID_BITS'(i);
    end
  end

  always_comb begin
    w_tag = '0;
    w_tag[DATA_BITS-1 -: CRC_BITS]          = {CRC_BITS{1'b1}};
    w_tag[MID_MSB -: MODULE_ID_BITS]        = module_id;
    w_tag[BID_MSB -: BLOCK_ID_BITS]         = w_blk_idx;
    w_tag[PERIOD_BITS-1:0]                  = r_period_snap;
  end

  // Reset parks the FSM in WAIT with a zero snapshot so that release emits period-0 tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_cnt  <= '0;
      r_div_cnt     <= '0;
      r_dropped     <= '0;
      r_state       <= S_WAIT;
      r_period_snap <= '0;
      r_mask_snap   <= block_mask;
      r_pend        <= '0;
    end else begin
      if (period_done) begin
        r_period_cnt <= r_period_cnt + PERIOD_BITS'(1);
        r_div_cnt    <= w_trigger ? '0 : r_div_cnt + DIV_BITS'(1);
      end
      if (w_trigger && (r_state != S_IDLE) && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_period_snap <= r_period_cnt + PERIOD_BITS'(1);
            r_mask_snap   <= block_mask;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((stall & r_mask_snap) == '0) begin
            r_pend  <= r_mask_snap;
            r_state <= (r_mask_snap != '0) ? S_EMIT : S_IDLE;
          end
        end
        S_EMIT: begin
          if (!w_full) begin
            r_pend <= w_pend_next;
            if (w_pend_next == '0) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign tt_valid      = (r_level != '0);
  assign tt            = tt_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level    = r_level;
  assign dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_time_tag_emitter.sv
`default_nettype none
//==============================================================================
// tb_time_tag_emitter
//   Directed scenarios plus random traffic against a queue-based tag model.
// Revision: 1.0
//==============================================================================
module tb_time_tag_emitter;

  localparam int PB    = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   module_id = 4'hA;
  logic         period_done = 1'b0;
  logic [3:0]   block_mask = 4'b0101;
  logic [3:0]   stall = 4'b0000;
  logic [7:0]   tag_div = 8'd0;
  logic         tt_ready = 1'b1;
  logic         tt_valid;
  logic [127:0] tt;
  logic [3:0]   fifo_level;
  logic [15:0]  dropped_count;

  always #5 clk = ~clk;

  time_tag_emitter #(
    .CRC_BITS(5), .MODULE_ID_BITS(4), .BLOCK_ID_BITS(2), .NUM_BLOCKS(NB),
    .PERIOD_BITS(PB), .DATA_BITS(128), .FIFO_DEPTH(DEPTH), .DIV_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .module_id(module_id), .period_done(period_done),
    .block_mask(block_mask), .stall(stall), .tag_div(tag_div),
    .tt_valid(tt_valid), .tt_ready(tt_ready), .tt(tt),
    .fifo_level(fifo_level), .dropped_count(dropped_count)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents, pending block list, trigger bookkeeping.
  logic [127:0] m_fifo[$];
  int           m_pend[$];
  int           m_phase;   // 0 idle, 1 waiting for stall release, 2 emitting
  int           m_pcnt, m_dcnt, m_snap, m_drops;
  logic [3:0]   m_msnap;
  logic [127:0] seen[$];

  function automatic logic [127:0] make_tag(input int blk, input int per);
    return {5'h1F, 1'b0, module_id, 2'(blk), 1'b0, 107'd0, 8'(per)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit trig, full, pop, push;
    logic [127:0] newtag;
    push = 1'b0;
    newtag = '0;
    if (rst) begin
      m_fifo.delete(); m_pend.delete();
      m_drops = 0; m_pcnt = 0; m_dcnt = 0;
      m_phase = 1; m_snap = 0; m_msnap = block_mask;
      return;
    end
    trig = period_done && (m_dcnt >= int'(tag_div));
    full = (m_fifo.size() >= DEPTH);
    pop  = (m_fifo.size() > 0) && tt_ready;
    if (trig && m_phase != 0 && m_drops < 65535) m_drops++;
    case (m_phase)
      0: if (trig) begin
           m_snap = (m_pcnt + 1) % (1 << PB);
           m_msnap = block_mask;
           m_phase = 1;
         end
      1: if ((stall & m_msnap) == 4'b0) begin
           for (int b = 0; b < NB; b++) if (m_msnap[b]) m_pend.push_back(b);
           m_phase = (m_pend.size() > 0) ? 2 : 0;
         end
      default: if (!full) begin
           newtag = make_tag(m_pend.pop_front(), m_snap);
           push = 1'b1;
           if (m_pend.size() == 0) m_phase = 0;
         end
    endcase
    if (pop) void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(newtag);
    if (period_done) begin
      m_pcnt = (m_pcnt + 1) % (1 << PB);
      m_dcnt = trig ? 0 : m_dcnt + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle output comparison and log of every handshake.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tt_valid", 128'(tt_valid), 128'(m_fifo.size() > 0));
      chk("fifo_level", 128'(fifo_level), 128'(m_fifo.size()));
      chk("dropped_count", 128'(dropped_count), 128'(m_drops));
      chk("tt", tt, (m_fifo.size() > 0) ? m_fifo[0] : 128'd0);
    end
    if (tt_valid && tt_ready) seen.push_back(tt);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int gap);
    period_done = 1'b1;
    tick(1);
    period_done = 1'b0;
    tick(gap - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] lit;
    tick(1);
    chk_en = 1'b1;
    tick(2);

    // Reset release: two period-0 tags for blocks 0 and 2.
    rst = 1'b0;
    seen.delete();
    tick(10);
    chk("s1_count", 128'(seen.size()), 128'd2);
    if (seen.size() >= 2) begin
      lit = {16'hFA80, 112'd0};
      chk("s1_tag_blk0", seen[0], lit);
      lit = {16'hFAA0, 112'd0};
      chk("s1_tag_blk2", seen[1], lit);
    end
    chk("s1_dropped", 128'(dropped_count), 128'd0);

    // Divider of 3: nine periods give tags at periods 3, 6, 9.
    tag_div = 8'd2;
    block_mask = 4'b0001;
    seen.delete();
    repeat (9) pulse(10);
    tick(5);
    chk("s2_count", 128'(seen.size()), 128'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      lit = seen[i];
      chk("s2_period", 128'(lit[7:0]), 128'(3 * (i + 1)));
    end

    // Stall holds emission until released.
    tag_div = 8'd0;
    block_mask = 4'b0011;
    stall = 4'b0010;
    seen.delete();
    pulse(20);
    chk("s3_stalled_level", 128'(fifo_level), 128'd0);
    stall = 4'b0000;
    tick(10);
    chk("s3_count", 128'(seen.size()), 128'd2);

    // Back-pressure: FIFO fills, third trigger holds, fourth is dropped.
    tt_ready = 1'b0;
    block_mask = 4'hF;
    pulse(10);
    pulse(10);
    chk("s4_level_full", 128'(fifo_level), 128'd8);
    pulse(10);
    pulse(10);
    chk("s4_dropped", 128'(dropped_count), 128'd1);
    seen.delete();
    tt_ready = 1'b1;
    tick(40);
    chk("s4_drain_count", 128'(seen.size()), 128'd12);
    // Period counter stood at 10 before this scenario, so trigger 3 carries 13.
    for (int i = 8; i < 12 && i < seen.size(); i++) begin
      lit = seen[i];
      chk("s4_third_period", 128'(lit[7:0]), 128'd13);
    end

    // Period wrap on an 8-bit counter.
    rst = 1'b1;
    block_mask = 4'b0001;
    tick(2);
    rst = 1'b0;
    tick(10);
    seen.delete();
    repeat (256) pulse(5);
    tick(5);
    chk("s5_count", 128'(seen.size()), 128'd256);
    if (seen.size() == 256) begin
      lit = seen[0];
      chk("s5_first", 128'(lit[7:0]), 128'd1);
      lit = seen[254];
      chk("s5_max", 128'(lit[7:0]), 128'd255);
      lit = seen[255];
      chk("s5_wrap", 128'(lit[7:0]), 128'd0);
    end

    // Reset mid-emission with three tags queued.
    tt_ready = 1'b0;
    block_mask = 4'hF;
    pulse(2);
    for (int i = 0; i < 20 && fifo_level != 4'd3; i++) tick(1);
    chk("s6_level_before_rst", 128'(fifo_level), 128'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s6_valid_after_rst", 128'(tt_valid), 128'd0);
    tt_ready = 1'b1;
    seen.delete();
    tick(15);
    chk("s6_count", 128'(seen.size()), 128'd4);
    for (int i = 0; i < seen.size(); i++) begin
      lit = seen[i];
      chk("s6_period0", 128'(lit[7:0]), 128'd0);
    end
    chk("s6_dropped", 128'(dropped_count), 128'd0);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 2500; c++) begin
      period_done = ($urandom_range(0, 5) == 0);
      stall       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      block_mask  = 4'($urandom);
      tag_div     = 8'($urandom_range(0, 3));
      tt_ready    = ($urandom_range(0, 9) < 7);
      module_id   = 4'($urandom);
      rst         = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    period_done = 1'b0;
    tt_ready = 1'b1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
